mem_write_arb: RTL and testbench
================================

# mem_write_arb

Write-port controller for the unified 2-read/1-write instruction/data memory. Shares the memory's single write port between the CPU store path and the debug/host port through a valid/ready handshake with registered outputs. Also contains a clear sequencer that sweeps every memory word to zero on command, stalling both requesters while it runs. Sits between the datapath/debug logic and the memory's `w_addr`/`w_data`/`w_en` inputs.

## Interface
Parameters:
- `N_ELEMENTS`, 128, number of memory words (≥2)
- `ADDR_WIDTH`, 16, address width in bits
- `DATA_WIDTH`, 16, data width in bits

Ports:
- `clk`  in  1  clock; single clock domain
- `rst`  in  1  synchronous, active-high reset
- `cpu_w_valid`  in  1  CPU write request
- `cpu_w_addr`  in  ADDR_WIDTH  CPU write address
- `cpu_w_data`  in  DATA_WIDTH  CPU write data
- `cpu_w_ready`  out  1  CPU request accepted this cycle
- `dbg_w_valid`  in  1  debug write request
- `dbg_w_addr`  in  ADDR_WIDTH  debug write address
- `dbg_w_data`  in  DATA_WIDTH  debug write data
- `dbg_w_ready`  out  1  debug request accepted this cycle
- `clr_start`  in  1  start clear sweep (single-cycle pulse)
- `clr_busy`  out  1  clear sweep in progress
- `clr_done`  out  1  one-cycle pulse after the final clear write
- `err_oob`  out  1  one-cycle pulse: accepted write had addr ≥ N_ELEMENTS
- `mem_w_addr`  out  ADDR_WIDTH  to memory `w_addr`
- `mem_w_data`  out  DATA_WIDTH  to memory `w_data`
- `mem_w_en`  out  1  to memory `w_en`

## Operation
- FSM states: IDLE and CLEAR. Reset → IDLE.
- IDLE:
  - A transfer occurs when `*_w_valid & *_w_ready` are both high.
  - At most one ready is high per cycle.
  - `*_w_ready` may depend on both valids. A valid must never depend on ready.
  - A requester holds valid, addr and data stable until accepted.
- Arbitration when both valids are high:
  - Round-robin: the requester not granted most recently wins.
  - `last_grant` resets to DBG, so CPU wins the first tie.
  - A lone valid is always granted immediately.
- Accepted write with addr < N_ELEMENTS: the next cycle drives `mem_w_en`=1 with the captured addr/data.
- Accepted write with addr ≥ N_ELEMENTS: it is consumed, `mem_w_en` stays 0 and `err_oob` pulses the next cycle. `last_grant` still updates.
- `clr_start` in IDLE:
  - Takes priority over both requesters; both readies are low that cycle.
  - Transition to CLEAR with counter = 0.
- CLEAR:
  - Each cycle writes data 0 to address = counter, then increments the counter.
  - After the write to N_ELEMENTS−1, return to IDLE.
  - Both readies are held low.
  - `clr_start` is ignored.
- Counter width is `$clog2(N_ELEMENTS)`, zero-extended to ADDR_WIDTH.
- Reset values: `mem_w_en`, `mem_w_addr`, `mem_w_data`, `clr_busy`, `clr_done`, `err_oob` are 0. `cpu_w_ready` and `dbg_w_ready` are 0 during the reset cycle.
- Reset mid-clear aborts the sweep. Next cycle: IDLE, all outputs 0, and the memory is left partially cleared.

## Timing
- Request accepted in cycle t: `mem_w_en` is high in cycle t+1. The memory commits at the end of t+1, and read ports see the new data in t+2.
- Back-to-back accepts are allowed: sustained throughput is one write per cycle.
- `clr_start` sampled in cycle t:
  - `clr_busy`=1 and `mem_w_en`=1 in cycles t+1 … t+N_ELEMENTS; clear write k is driven in cycle t+1+k.
  - `clr_done`=1 and `clr_busy`=0 in cycle t+N_ELEMENTS+1.
  - Readies may go high again from t+N_ELEMENTS+1.
- `mem_w_*` are all registered outputs. Readies are combinational from state, valids and `last_grant`.

## Configuration
- `MEM_WRITE_ARB_RR_EN` defined: round-robin arbitration as described above.
- `MEM_WRITE_ARB_RR_EN` undefined: fixed priority, CPU always wins a tie, and `last_grant` is not implemented. DBG can starve while `cpu_w_valid` stays high.

## Structure
- Shared package holds:
  - State enum `mem_arb_state_t` {IDLE, CLEAR}
  - Requester ID constants `REQ_CPU`=0, `REQ_DBG`=1
- One sub-module: `rr_arb2`, a 2-input arbiter (request pair and `last_grant` in, one-hot grant out). It honours `MEM_WRITE_ARB_RR_EN`.
- FSM, clear counter and output registers stay in the top module.

## Test plan
- Lone CPU write addr 0x0005 data 0xBEEF at t → `cpu_w_ready`=1 at t; `mem_w_en`=1, addr 0x0005, data 0xBEEF at t+1.
- CPU and DBG both valid for 4 cycles after reset (RR build) → grants CPU, DBG, CPU, DBG. Fixed-priority build → CPU all 4 cycles with DBG ready=0.
- DBG write addr 0x0080, N_ELEMENTS=128 → accepted; `mem_w_en`=0 and `err_oob`=1 the next cycle.
- `clr_start` at t with N_ELEMENTS=8 → zero writes to addr 0..7 in t+1..t+8; `clr_busy` high over t+1..t+8; `clr_done` pulses at t+9. CPU valid held throughout is accepted at t+9.
- `rst` asserted during clear write 3 → next cycle IDLE, all outputs 0; `clr_done` never pulses.
- `clr_start` coincident with CPU valid → CPU ready=0 that cycle; the CPU write is issued only after `clr_done`.

Source files
------------

// File: rtl/mem_write_arb_pkg.sv
//============================================================================
// Module   : mem_write_arb_pkg
// Brief    : Shared types and constants for the memory write-port arbiter.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

package mem_write_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } mem_arb_state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mem_write_arb_rr_arb2.sv
//============================================================================
// Module   : rr_arb2
// Brief    : Two-input arbiter, one-hot grant. Round-robin on a tie when
//            MEM_WRITE_ARB_RR_EN is defined, otherwise CPU has fixed priority.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module rr_arb2
    import mem_write_arb_pkg::*;
(
`ifdef MEM_WRITE_ARB_RR_EN
    input  logic       last_grant,
`endif
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req[REQ_CPU] && req[REQ_DBG]) begin
`ifdef MEM_WRITE_ARB_RR_EN
            if (last_grant == REQ_DBG) begin
                gnt[REQ_CPU] = 1'b1;
            end else begin
                gnt[REQ_DBG] = 1'b1;
            end
`else
            gnt[REQ_CPU] = 1'b1;
`endif
        end else begin
            gnt = req;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_write_arb.sv
//============================================================================
// Module   : mem_write_arb
// Brief    : Shares the memory write port between CPU and debug requesters and
//            runs a zero-fill clear sweep. Option macro: MEM_WRITE_ARB_RR_EN.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module mem_write_arb
    import mem_write_arb_pkg::*;
#(
    parameter int N_ELEMENTS = 128,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_w_valid,
    input  logic [ADDR_WIDTH-1:0] cpu_w_addr,
    input  logic [DATA_WIDTH-1:0] cpu_w_data,
    output logic                  cpu_w_ready,
    input  logic                  dbg_w_valid,
    input  logic [ADDR_WIDTH-1:0] dbg_w_addr,
    input  logic [DATA_WIDTH-1:0] dbg_w_data,
    output logic                  dbg_w_ready,
    input  logic                  clr_start,
    output logic                  clr_busy,
    output logic                  clr_done,
    output logic                  err_oob,
    output logic [ADDR_WIDTH-1:0] mem_w_addr,
    output logic [DATA_WIDTH-1:0] mem_w_data,
    output logic                  mem_w_en
);

    localparam int              CW      = $clog2(N_ELEMENTS);
    localparam logic [CW-1:0]   C_LAST  = CW'(N_ELEMENTS - 1);
    localparam logic [CW-1:0]   C_ONE   = CW'(1);
    localparam logic [ADDR_WIDTH:0] C_N_EXT = (ADDR_WIDTH + 1)'(N_ELEMENTS);

    mem_arb_state_t          r_state;
    mem_arb_state_t          w_state_nxt;
    logic [CW-1:0]           r_cnt;
    logic [CW-1:0]           w_cnt_inc;
    logic [1:0]              w_req;
    logic [1:0]              w_gnt;
    logic                    w_arb_en;
    logic                    w_accept;
    logic                    w_oob;
    logic                    w_last_clr;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [DATA_WIDTH-1:0]   w_sel_data;

    assign w_req = {dbg_w_valid, cpu_w_valid};

`ifdef MEM_WRITE_ARB_RR_EN
    logic r_last_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= REQ_DBG;
        end else if (w_accept) begin
            r_last_grant <= dbg_w_ready ? REQ_DBG : REQ_CPU;
        end
    end

    rr_arb2 u_arb (
        .last_grant (r_last_grant),
        .req        (w_req),
        .gnt        (w_gnt)
    );
`else
    rr_arb2 u_arb (
        .req        (w_req),
        .gnt        (w_gnt)
    );
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (clr_start)  w_state_nxt = CLEAR;
            CLEAR:   if (w_last_clr) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output logic: a clear request pre-empts both requesters in the same cycle
    always_comb begin
        w_arb_en    = (r_state == IDLE) && !clr_start && !rst;
        cpu_w_ready = w_arb_en && w_gnt[REQ_CPU];
        dbg_w_ready = w_arb_en && w_gnt[REQ_DBG];
    end

    assign w_accept   = cpu_w_ready || dbg_w_ready;
    assign w_sel_addr = dbg_w_ready ? dbg_w_addr : cpu_w_addr;
    assign w_sel_data = dbg_w_ready ? dbg_w_data : cpu_w_data;
    assign w_oob      = {1'b0, w_sel_addr} >= C_N_EXT;
    assign w_last_clr = (r_cnt == C_LAST);
    assign w_cnt_inc  = r_cnt + C_ONE;

    // r_cnt always holds the address currently being cleared
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            mem_w_en   <= 1'b0;
            mem_w_addr <= '0;
            mem_w_data <= '0;
            clr_busy   <= 1'b0;
            clr_done   <= 1'b0;
            err_oob    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    clr_done <= 1'b0;
                    if (clr_start) begin
                        r_cnt      <= '0;
                        mem_w_en   <= 1'b1;
                        mem_w_addr <= '0;
                        mem_w_data <= '0;
                        clr_busy   <= 1'b1;
                        err_oob    <= 1'b0;
                    end else if (w_accept) begin
                        mem_w_en   <= !w_oob;
                        mem_w_addr <= w_sel_addr;
                        mem_w_data <= w_sel_data;
                        err_oob    <= w_oob;
                    end else begin
                        mem_w_en   <= 1'b0;
                        err_oob    <= 1'b0;
                    end
                end
                CLEAR: begin
                    err_oob <= 1'b0;
                    if (w_last_clr) begin
                        mem_w_en <= 1'b0;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        r_cnt      <= w_cnt_inc;
                        mem_w_en   <= 1'b1;
                        mem_w_addr <= ADDR_WIDTH'(w_cnt_inc);
                        mem_w_data <= '0;
                    end
                end
                default: begin
                    mem_w_en <= 1'b0;
                    clr_busy <= 1'b0;
                    clr_done <= 1'b0;
                    err_oob  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_write_arb.sv
//============================================================================
// Module   : tb_mem_write_arb
// Brief    : Self-checking bench for mem_write_arb (N_ELEMENTS=8), directed
//            cases plus randomized traffic against a queue-based model.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_mem_write_arb;

    localparam int N  = 8;
    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_w_valid, dbg_w_valid, clr_start;
    logic [AW-1:0] cpu_w_addr, dbg_w_addr;
    logic [DW-1:0] cpu_w_data, dbg_w_data;
    logic          cpu_w_ready, dbg_w_ready;
    logic          clr_busy, clr_done, err_oob, mem_w_en;
    logic [AW-1:0] mem_w_addr;
    logic [DW-1:0] mem_w_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_write_arb #(.N_ELEMENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_w_valid (cpu_w_valid),
        .cpu_w_addr  (cpu_w_addr),
        .cpu_w_data  (cpu_w_data),
        .cpu_w_ready (cpu_w_ready),
        .dbg_w_valid (dbg_w_valid),
        .dbg_w_addr  (dbg_w_addr),
        .dbg_w_data  (dbg_w_data),
        .dbg_w_ready (dbg_w_ready),
        .clr_start   (clr_start),
        .clr_busy    (clr_busy),
        .clr_done    (clr_done),
        .err_oob     (err_oob),
        .mem_w_addr  (mem_w_addr),
        .mem_w_data  (mem_w_data),
        .mem_w_en    (mem_w_en)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        @(negedge clk);
        #1;
    endtask

    // Reference model: expected outputs for the current cycle plus a queue of
    // addresses still to be cleared.
    bit            started = 1'b0;
    logic          m_en = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_oob = 1'b0;
    logic          m_rst_last = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    bit            m_last = 1'b1;
    int            clr_q[$];
    logic          e_cr, e_dr;
    logic [AW-1:0] a_sel;

    always @(negedge clk) begin
        e_cr = 1'b0;
        e_dr = 1'b0;
        if (!rst && !m_busy && !clr_start) begin
            if (cpu_w_valid && dbg_w_valid) begin
`ifdef MEM_WRITE_ARB_RR_EN
                if (m_last) e_cr = 1'b1;
                else        e_dr = 1'b1;
`else
                e_cr = 1'b1;
`endif
            end else begin
                e_cr = cpu_w_valid;
                e_dr = dbg_w_valid;
            end
        end

        if (started) begin
            chk("model_cpu_ready", 32'(cpu_w_ready), 32'(e_cr));
            chk("model_dbg_ready", 32'(dbg_w_ready), 32'(e_dr));
            chk("model_mem_w_en",  32'(mem_w_en),    32'(m_en));
            chk("model_clr_busy",  32'(clr_busy),    32'(m_busy));
            chk("model_clr_done",  32'(clr_done),    32'(m_done));
            chk("model_err_oob",   32'(err_oob),     32'(m_oob));
            if (m_en || m_rst_last) begin
                chk("model_mem_w_addr", 32'(mem_w_addr), 32'(m_addr));
                chk("model_mem_w_data", 32'(mem_w_data), 32'(m_data));
            end
        end

        m_rst_last = 1'b0;
        if (rst) begin
            started    = 1'b1;
            m_rst_last = 1'b1;
            m_en = 0; m_busy = 0; m_done = 0; m_oob = 0;
            m_addr = '0; m_data = '0; m_last = 1'b1;
            clr_q.delete();
        end else if (m_busy) begin
            m_oob = 0;
            if (clr_q.size() > 0) begin
                m_en = 1; m_busy = 1; m_done = 0;
                m_addr = AW'(clr_q.pop_front());
                m_data = '0;
            end else begin
                m_en = 0; m_busy = 0; m_done = 1;
            end
        end else if (clr_start) begin
            for (int i = 0; i < N; i++) clr_q.push_back(i);
            m_en = 1; m_busy = 1; m_done = 0; m_oob = 0;
            m_addr = AW'(clr_q.pop_front());
            m_data = '0;
        end else begin
            m_done = 0;
            m_busy = 0;
            if (e_cr || e_dr) begin
                a_sel  = e_cr ? cpu_w_addr : dbg_w_addr;
                m_last = e_dr;
                if (a_sel < AW'(N)) begin
                    m_en = 1; m_oob = 0;
                    m_addr = a_sel;
                    m_data = e_cr ? cpu_w_data : dbg_w_data;
                end else begin
                    m_en = 0; m_oob = 1;
                end
            end else begin
                m_en = 0; m_oob = 0;
            end
        end
    end

    logic cg, dg, cacc, dacc;
    int   done_cnt;

    initial begin
        rst = 1'b1; clr_start = 1'b0;
        cpu_w_valid = 1'b0; cpu_w_addr = '0; cpu_w_data = '0;
        dbg_w_valid = 1'b0; dbg_w_addr = '0; dbg_w_data = '0;
        tick(); tick();
        rst = 1'b0;

        probe();
        chk("reset_mem_w_en",   32'(mem_w_en),   32'h0);
        chk("reset_mem_w_addr", 32'(mem_w_addr), 32'h0);
        chk("reset_clr_busy",   32'(clr_busy),   32'h0);

        // Lone CPU write
        tick();
        cpu_w_valid = 1'b1; cpu_w_addr = 16'h0005; cpu_w_data = 16'hBEEF;
        probe();
        chk("lone_cpu_ready", 32'(cpu_w_ready), 32'h1);
        tick();
        cpu_w_valid = 1'b0;
        probe();
        chk("lone_mem_w_en",   32'(mem_w_en),   32'h1);
        chk("lone_mem_w_addr", 32'(mem_w_addr), 32'h0005);
        chk("lone_mem_w_data", 32'(mem_w_data), 32'hBEEF);

        // Tie sequence from a fresh reset
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        cpu_w_valid = 1'b1; cpu_w_addr = 16'h0001; cpu_w_data = 16'h1111;
        dbg_w_valid = 1'b1; dbg_w_addr = 16'h0002; dbg_w_data = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            probe();
            cg = cpu_w_ready;
            dg = dbg_w_ready;
`ifdef MEM_WRITE_ARB_RR_EN
            chk("tie_cpu_ready", 32'(cg), (i % 2 == 0) ? 32'h1 : 32'h0);
            chk("tie_dbg_ready", 32'(dg), (i % 2 == 0) ? 32'h0 : 32'h1);
`else
            chk("tie_cpu_ready", 32'(cg), 32'h1);
            chk("tie_dbg_ready", 32'(dg), 32'h0);
`endif
            tick();
            if (cg) begin cpu_w_addr = AW'(i + 3); cpu_w_data = DW'(16'h3000 + i); end
            if (dg) begin dbg_w_addr = AW'(i + 4); dbg_w_data = DW'(16'h4000 + i); end
        end
        cpu_w_valid = 1'b0; dbg_w_valid = 1'b0;
        tick();

        // Out-of-range debug write
        dbg_w_valid = 1'b1; dbg_w_addr = 16'h0080; dbg_w_data = 16'h1234;
        probe();
        chk("oob_dbg_ready", 32'(dbg_w_ready), 32'h1);
        tick();
        dbg_w_valid = 1'b0;
        probe();
        chk("oob_mem_w_en", 32'(mem_w_en), 32'h0);
        chk("oob_err_oob",  32'(err_oob),  32'h1);

        // Clear sweep with a CPU request pending throughout
        tick();
        clr_start = 1'b1;
        cpu_w_valid = 1'b1; cpu_w_addr = 16'h0003; cpu_w_data = 16'hA5A5;
        probe();
        chk("clr_start_cpu_ready", 32'(cpu_w_ready), 32'h0);
        tick();
        clr_start = 1'b0;
        for (int k = 0; k < N; k++) begin
            probe();
            chk("clr_mem_w_en",   32'(mem_w_en),    32'h1);
            chk("clr_mem_w_addr", 32'(mem_w_addr),  32'(k));
            chk("clr_busy",       32'(clr_busy),    32'h1);
            chk("clr_cpu_ready",  32'(cpu_w_ready), 32'h0);
            tick();
        end
        probe();
        chk("clr_done_pulse",  32'(clr_done),    32'h1);
        chk("clr_done_busy",   32'(clr_busy),    32'h0);
        chk("clr_after_ready", 32'(cpu_w_ready), 32'h1);
        tick();
        cpu_w_valid = 1'b0;
        probe();
        chk("clr_after_en",   32'(mem_w_en),   32'h1);
        chk("clr_after_addr", 32'(mem_w_addr), 32'h0003);
        chk("clr_after_data", 32'(mem_w_data), 32'hA5A5);

        // Reset during clear write 3
        tick(); clr_start = 1'b1;
        tick(); clr_start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        probe();
        chk("abort_write3_addr", 32'(mem_w_addr), 32'h3);
        tick();
        rst = 1'b0;
        probe();
        chk("abort_mem_w_en", 32'(mem_w_en), 32'h0);
        chk("abort_clr_busy", 32'(clr_busy), 32'h0);
        chk("abort_addr",     32'(mem_w_addr), 32'h0);
        done_cnt = 0;
        for (int i = 0; i < N + 3; i++) begin
            if (clr_done) done_cnt++;
            tick();
            probe();
        end
        chk("abort_no_done", 32'(done_cnt), 32'h0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            probe();
            cacc = cpu_w_valid && cpu_w_ready;
            dacc = dbg_w_valid && dbg_w_ready;
            tick();
            if (!cpu_w_valid || cacc) begin
                cpu_w_valid = ($urandom_range(0, 9) < 6);
                cpu_w_addr  = AW'($urandom_range(0, 11));
                cpu_w_data  = DW'($urandom);
            end
            if (!dbg_w_valid || dacc) begin
                dbg_w_valid = ($urandom_range(0, 9) < 5);
                dbg_w_addr  = AW'($urandom_range(0, 11));
                dbg_w_data  = DW'($urandom);
            end
            clr_start = ($urandom_range(0, 59) == 0);
            rst       = ($urandom_range(0, 249) == 0);
        end
        cpu_w_valid = 1'b0; dbg_w_valid = 1'b0; clr_start = 1'b0; rst = 1'b0;
        repeat (N + 4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
